// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared FSM encodings and grant constants for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    localparam logic c_GRANT_INSTR = 1'b0;
    localparam logic c_GRANT_DATA  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_grant.sv
// ============================================================================
// Module      : arb_grant
// Description : Instruction/data grant selection. Data wins a tie unless the
//               previous grant went to data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_i,
    output logic grant_d
);

    assign grant_d = d_req & (~i_req | (last_grant == c_GRANT_INSTR));
    assign grant_i = i_req & ~grant_d;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates fetch and data ports onto one memory port.
//               Define MEM_ARB_RR_EN for alternating priority on ties.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              stall
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_sel_d;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_last_grant;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_busy;
    logic              w_idle;

    arb_grant u_arb_grant (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (w_last_grant),
        .grant_i    (w_grant_i),
        .grant_d    (w_grant_d)
    );

`ifdef MEM_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= c_GRANT_INSTR;
        end else if (w_idle && (w_grant_i || w_grant_d)) begin
            r_last_grant <= w_grant_d ? c_GRANT_DATA : c_GRANT_INSTR;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = c_GRANT_INSTR;
`endif

    assign w_idle = (r_state == ARB_IDLE);
    assign w_busy = (r_state == ARB_IBUSY) || (r_state == ARB_DBUSY);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = ARB_DBUSY;
                end else if (w_grant_i) begin
                    w_next_state = ARB_IBUSY;
                end
            end
            ARB_IBUSY, ARB_DBUSY: begin
                if (m_ready) begin
                    w_next_state = ARB_DONE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_sel_d   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_idle && w_grant_d) begin
                r_sel_d <= 1'b1;
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else if (w_idle && w_grant_i) begin
                r_sel_d <= 1'b0;
                r_we    <= 1'b0;
                r_addr  <= i_addr;
                r_wdata <= '0;
            end
            // Writes complete without touching the read-data registers
            if (w_busy && m_ready && !r_we) begin
                if (r_sel_d) begin
                    r_d_rdata <= m_rdata;
                end else begin
                    r_i_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_req   = w_busy;
    assign m_we    = r_we & w_busy;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_ack   = (r_state == ARB_DONE) && !r_sel_d;
    assign d_ack   = (r_state == ARB_DONE) &&  r_sel_d;
    assign stall   = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a variable-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int c_AW = 32;
    localparam int c_DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req;
    logic [c_AW-1:0] i_addr;
    logic [c_DW-1:0] i_rdata;
    logic            i_ack;
    logic            d_req;
    logic            d_we;
    logic [c_AW-1:0] d_addr;
    logic [c_DW-1:0] d_wdata;
    logic [c_DW-1:0] d_rdata;
    logic            d_ack;
    logic            m_req;
    logic            m_we;
    logic [c_AW-1:0] m_addr;
    logic [c_DW-1:0] m_wdata;
    logic [c_DW-1:0] m_rdata;
    logic            m_ready;
    logic            stall;

    typedef struct {
        bit          side_d;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          wait_cycles = 0;
    int          busy_cnt;
    logic [31:0] exp_drd = '0;
    bit          model_last_d = 1'b0;

    mem_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5A0000) + 32'h1111);
    endfunction

    // Memory holds m_ready low for wait_cycles cycles of each request
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (m_req && !m_ready) begin
            busy_cnt <= busy_cnt + 1;
        end else begin
            busy_cnt <= 0;
        end
    end

    assign m_ready = m_req && (busy_cnt >= wait_cycles);
    assign m_rdata = mem_val(m_addr);

    task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(bit side_d, bit we, logic [31:0] addr);
        exp_t e;
        e.side_d = side_d;
        if (side_d) begin
            if (!we) exp_drd = mem_val(addr);
            e.rdata = exp_drd;
        end else begin
            e.rdata = mem_val(addr);
        end
        sb.push_back(e);
        model_last_d = side_d;
    endtask

    always @(negedge clk) begin
        if (!rst && (i_ack || d_ack)) begin
            exp_t e;
            check_val("ack_exclusive", {63'd0, i_ack & d_ack}, 64'd0);
            check_val("m_req_in_done", {63'd0, m_req}, 64'd0);
            check_val("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("ack_side", {63'd0, d_ack}, {63'd0, e.side_d});
                check_val("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
            end
        end
    end

    // Called on a negedge with the arbiter idle; returns one cycle after the ack
    task automatic single(bit side_d, bit we, logic [31:0] addr, logic [31:0] wdata,
                          int wt, bit field_chk);
        int cyc;
        bit done;
        wait_cycles = wt;
        push_exp(side_d, we, addr);
        if (side_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        #1 check_val("stall_cycle0", {63'd0, stall}, 64'd1);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (side_d ? d_ack : i_ack) begin
                done = 1'b1;
            end else begin
                check_val("stall_busy", {63'd0, stall}, 64'd1);
                if (field_chk) begin
                    check_val("m_req", {63'd0, m_req}, 64'd1);
                    check_val("m_addr", m_addr, addr);
                    check_val("m_we", {63'd0, m_we}, {63'd0, we});
                    if (we) check_val("m_wdata", m_wdata, wdata);
                end
            end
        end
        check_val("latency", cyc, 2 + wt);
        if (done) check_val("stall_at_ack", {63'd0, stall}, 64'd0);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic both(logic [31:0] iaddr, logic [31:0] daddr, int wt);
        bit first_d;
        int cyc;
        int cyc_i;
        int cyc_d;
`ifdef MEM_ARB_RR_EN
        first_d = !model_last_d;
`else
        first_d = 1'b1;
`endif
        wait_cycles = wt;
        push_exp(first_d, 1'b0, first_d ? daddr : iaddr);
        push_exp(!first_d, 1'b0, first_d ? iaddr : daddr);
        i_req = 1'b1; i_addr = iaddr;
        d_req = 1'b1; d_we = 1'b0; d_addr = daddr;
        cyc = 0; cyc_i = -1; cyc_d = -1;
        while ((cyc_i < 0 || cyc_d < 0) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (i_ack) begin cyc_i = cyc; i_req = 1'b0; end
            if (d_ack) begin cyc_d = cyc; d_req = 1'b0; end
        end
        check_val("both_first_ack", first_d ? cyc_d : cyc_i, 2 + wt);
        check_val("both_second_ack", first_d ? cyc_i : cyc_d, 5 + 2 * wt);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        check_val("rst_m_req", {63'd0, m_req}, 64'd0);
        check_val("rst_acks", {62'd0, i_ack, d_ack}, 64'd0);
        check_val("rst_m_addr", m_addr, 32'd0);
        check_val("rst_rdata", {i_rdata, d_rdata}, 64'd0);
        rst = 1'b0;

        single(1'b0, 1'b0, 32'h100, 32'h0, 0, 1'b1);
        single(1'b1, 1'b1, 32'h40, 32'h12345678, 3, 1'b1);
        single(1'b1, 1'b0, 32'h44, 32'h0, 1, 1'b1);
        single(1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 0, 1'b1);
        both(32'h300, 32'h60, 0);
        both(32'h304, 32'h64, 1);
        both(32'h308, 32'h68, 0);
        for (int k = 0; k < 4; k++) begin
            bit sd;
            sd = 1'($urandom_range(0, 1));
            single(sd, sd & 1'($urandom_range(0, 1)), $urandom & 32'h0000FFFC,
                   $urandom, int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset in the middle of a stalled data read
        wait_cycles = 10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        @(negedge clk);
        check_val("pre_rst_m_req", {63'd0, m_req}, 64'd1);
        #1 rst = 1'b1;
        #1;
        check_val("midrst_m_req", {63'd0, m_req}, 64'd0);
        check_val("midrst_d_ack", {63'd0, d_ack}, 64'd0);
        check_val("midrst_m_addr", m_addr, 32'd0);
        check_val("midrst_rdata", {i_rdata, d_rdata}, 64'd0);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_last_d = 1'b0;
        exp_drd = '0;
        single(1'b0, 1'b0, 32'h200, 32'h0, 0, 1'b1);
        both(32'h210, 32'h90, 0);
        check_val("sb_drained", sb.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_req  input  1  fetch-side read request, held until i_ack.
REQ-006 SHALL have port i_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have port i_rdata  output  DATA_W  fetch read data, valid while i_ack is high.
REQ-008 SHALL have port i_ack  output  1  fetch completion pulse.
REQ-009 SHALL have port d_req  input  1  data-side request, held until d_ack.
REQ-010 SHALL have port d_we  input  1  data-side write enable (1 write, 0 read).
REQ-011 SHALL have port d_addr  input  ADDR_W  data address.
REQ-012 SHALL have port d_wdata  input  DATA_W  data write value.
REQ-013 SHALL have port d_rdata  output  DATA_W  data read value, valid while d_ack is high.
REQ-014 SHALL have port d_ack  output  1  data completion pulse.
REQ-015 SHALL have ports m_req, m_we (output 1), m_addr (output ADDR_W), m_wdata (output DATA_W): shared memory port request.
REQ-016 SHALL have ports m_rdata (input DATA_W) and m_ready (input 1): memory read data and completion.
REQ-017 SHALL have port stall  output  1  pipeline stall, combinational: (i_req & ~i_ack) | (d_req & ~d_ack).

Function
REQ-018 SHALL implement FSM states IDLE, IBUSY, DBUSY, DONE.
REQ-019 In IDLE, SHALL sample requests at the clock edge and register address, we, and wdata of the winner; next state IBUSY or DBUSY.
REQ-020 In IBUSY/DBUSY, SHALL drive m_req=1 with the registered fields held stable until the edge at which m_ready=1.
REQ-021 At the edge where m_ready=1, SHALL capture m_rdata into the winner's rdata register (reads only) and enter DONE.
REQ-022 In DONE, SHALL assert the winner's ack for exactly one cycle, accept no new request, and return to IDLE.
REQ-023 Minimum request-to-ack latency SHALL be 2 cycles (m_ready high in the first BUSY cycle); each additional m_ready-low cycle SHALL add one cycle.
REQ-024 i_ack and d_ack SHALL never be high in the same cycle; m_req SHALL be 0 in IDLE and DONE.
REQ-025 A write SHALL leave d_rdata unchanged; d_ack SHALL still pulse.
REQ-026 If a request drops mid-transaction, the transaction SHALL complete and the ack SHALL still pulse (protocol violation, not recovered).
REQ-027 Without RR (see Configuration), simultaneous i_req and d_req in IDLE SHALL grant data first.

Reset
REQ-028 On rst, SHALL enter IDLE immediately, including mid-transaction, with m_req=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, and last-grant=instruction.
REQ-029 After rst deasserts, the first request SHALL be sampled at the next rising edge.

Configuration
REQ-030 With macro MEM_ARB_RR_EN defined, simultaneous requests SHALL grant the side not granted last. The last-grant flop SHALL update on every grant.
REQ-031 Without MEM_ARB_RR_EN, fixed data-over-instruction priority SHALL apply, and no last-grant flop SHALL exist.

Structure
REQ-032 FSM state encodings (2-bit) SHALL live in the shared defines file as ARB_IDLE, ARB_IBUSY, ARB_DBUSY, ARB_DONE.
REQ-033 Grant selection SHALL be a sub-module, arb_grant (inputs i_req, d_req, last_grant; outputs grant_i, grant_d); all other logic is flat.

Verification
REQ-034 Lone i_req, i_addr=0x100, m_ready=1 immediately, m_rdata=0xDEADBEEF -> m_addr=0x100 in cycle 1, i_ack and i_rdata=0xDEADBEEF in cycle 2.
REQ-035 d_req write, d_addr=0x40, d_wdata=0x12345678, m_ready low 3 cycles -> m_we=1 and fields stable for 4 cycles, d_ack in cycle 5, stall high cycles 0-4.
REQ-036 i_req and d_req together, fixed priority -> data served first, then instruction. Acks pulse in cycles 2 and 5.
REQ-037 MEM_ARB_RR_EN, both requesting continuously -> grants alternate D, I, D, I (last-grant reset = instruction).
REQ-038 rst asserted in DBUSY with m_ready=0 -> same cycle m_req=0, no d_ack. After release, a new i_req is served in 2 cycles.
